orb_serializer: RTL

ORB_SERIALIZER -- requirements
Module: orb_serializer

---
 rtl/orb_serializer.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/orb_serializer.sv
`default_nettype none
// ============================================================================
// Module   : orb_serializer
// Brief    : Streams 1024-word ORB frames from a latency-RD_LAT buffer as
//            Manchester chips, MSB first, gap-free across words and frames.
// Revision : 1.0
// ============================================================================
module orb_serializer #(
  parameter int HALF_BIT = 20,
  parameter int RD_LAT   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [11:0] orbRdData,
  output logic [9:0]  orbRdAddr,
  output logic        orbRdEn,
  output logic        orbSwitch,
  output logic        mOut,
  output logic        frameStrobe
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRIME_RD   = 2'd1,
    PRIME_WAIT = 2'd2,
    SHIFT      = 2'd3
  } state_t;

  localparam logic [7:0] c_halfLast = 8'(HALF_BIT - 1);
  localparam logic [2:0] c_waitLast = 3'(RD_LAT - 1);
  localparam logic [9:0] c_lastWord = 10'h3FF;

  state_t            r_state;
  logic [7:0]        r_halfCnt;
  logic              r_phase;
  logic [3:0]        r_bitCnt;
  logic [9:0]        r_wordAddr;
  logic [11:0]       r_shift;
  logic [11:0]       r_nextWord;
  logic [2:0]        r_waitCnt;
  logic [RD_LAT-1:0] r_rdPipe;
  logic              r_pfPending;

  logic        w_halfEnd;
  logic        w_wordEnd;
  logic        w_stop;
  logic        w_load;
  logic [11:0] w_loadData;
  logic [9:0]  w_loadAddr;

  assign w_halfEnd  = (r_halfCnt == c_halfLast);
  assign w_wordEnd  = (r_state == SHIFT) && w_halfEnd && r_phase && (r_bitCnt == 4'd0);
  assign w_stop     = (r_wordAddr == c_lastWord) && !enable;
  assign w_load     = ((r_state == PRIME_WAIT) && (r_waitCnt == c_waitLast)) ||
                      (w_wordEnd && !w_stop);
  assign w_loadData = (r_state == PRIME_WAIT) ? orbRdData : r_nextWord;
  assign w_loadAddr = (r_state == PRIME_WAIT) ? 10'd0 : r_wordAddr + 10'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_halfCnt   <= 8'd0;
      r_phase     <= 1'b0;
      r_bitCnt    <= 4'd0;
      r_wordAddr  <= 10'd0;
      r_shift     <= 12'd0;
      r_nextWord  <= 12'd0;
      r_waitCnt   <= 3'd0;
      r_rdPipe    <= '0;
      r_pfPending <= 1'b0;
      orbRdAddr   <= 10'd0;
      orbRdEn     <= 1'b0;
      orbSwitch   <= 1'b0;
      mOut        <= 1'b0;
      frameStrobe <= 1'b0;
    end else begin
      orbRdEn     <= 1'b0;
      frameStrobe <= 1'b0;
      // Tracks outstanding reads so the next word lands exactly RD_LAT cycles later
      r_rdPipe    <= (r_rdPipe << 1) | RD_LAT'(orbRdEn);

      case (r_state)
        IDLE: begin
          mOut <= 1'b0;
          if (enable) begin
            r_state    <= PRIME_RD;
            orbRdEn    <= 1'b1;
            orbRdAddr  <= 10'd0;
            r_wordAddr <= 10'd0;
          end
        end
        PRIME_RD: begin
          r_state   <= PRIME_WAIT;
          r_waitCnt <= 3'd0;
        end
        PRIME_WAIT: begin
          if (r_waitCnt == c_waitLast) r_state <= SHIFT;
          else                         r_waitCnt <= r_waitCnt + 3'd1;
        end
        SHIFT: begin
          if (r_rdPipe[RD_LAT-1]) r_nextWord <= orbRdData;
          if (r_pfPending) begin
            r_pfPending <= 1'b0;
            orbRdEn     <= 1'b1;
            orbRdAddr   <= r_wordAddr + 10'd1;
          end
          if (w_halfEnd) begin
            r_halfCnt <= 8'd0;
            if (!r_phase) begin
              r_phase <= 1'b1;
              mOut    <= ~r_shift[11];
            end else if (r_bitCnt != 4'd0) begin
              r_phase  <= 1'b0;
              r_bitCnt <= r_bitCnt - 4'd1;
              r_shift  <= {r_shift[10:0], 1'b0};
              mOut     <= r_shift[10];
            end else if (w_stop) begin
              r_state <= IDLE;
              mOut    <= 1'b0;
            end
          end else begin
            r_halfCnt <= r_halfCnt + 8'd1;
          end
        end
        default: r_state <= IDLE;
      endcase

      // Word load; the frame's last word hands the buffer half over first,
      // then the next-frame prefetch goes out one cycle later.
      if (w_load) begin
        r_shift     <= w_loadData;
        mOut        <= w_loadData[11];
        r_bitCnt    <= 4'd11;
        r_halfCnt   <= 8'd0;
        r_phase     <= 1'b0;
        r_wordAddr  <= w_loadAddr;
        frameStrobe <= (w_loadAddr == 10'd0);
        if (w_loadAddr == c_lastWord) begin
          orbSwitch   <= ~orbSwitch;
          r_pfPending <= 1'b1;
        end else begin
          orbRdEn   <= 1'b1;
          orbRdAddr <= w_loadAddr + 10'd1;
        end
      end
    end
  end

endmodule
`default_nettype wire
